// File: rtl/trace_dispatcher_if.sv
// Trace record handshake plus the shared L1 cache command bus.
// slave: the dispatcher's view; master: the trace source / cache model view.
interface trace_dispatcher_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ADDR_W = 60;
    localparam int unsigned CMD_W  = 3;

    logic              trace_valid;
    logic [OP_W-1:0]   trace_op;
    logic [ADDR_W-1:0] trace_addr;
    logic              trace_ready;
    logic [CMD_W-1:0]  command;
    logic [ADDR_W-1:0] address;
    logic              write_d;
    logic              write_i;
    logic              processing_d;
    logic              processing_i;

    modport slave (
        input  trace_valid, trace_op, trace_addr, processing_d, processing_i,
        output trace_ready, command, address, write_d, write_i
    );

    modport master (
        output trace_valid, trace_op, trace_addr, processing_d, processing_i,
        input  trace_ready, command, address, write_d, write_i
    );
endinterface

// File: rtl/trace_dispatcher.sv
// trace_dispatcher: routes trace records to the L1 data/instruction caches,
// sequences each cache's write strobe against its processing flag, and keeps
// retire/error statistics.
// Optional feature macro: TRACE_DISPATCH_TIMEOUT_EN (ISSUE timeout + timeout_count).
module trace_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    trace_dispatcher_if.slave   bus,
    output logic                print_pulse,
    output logic                busy,
    output logic [31:0]         dispatched_count,
`ifdef TRACE_DISPATCH_TIMEOUT_EN
    output logic [15:0]         timeout_count,
`endif
    output logic [15:0]         error_count
);
    localparam int unsigned ADDR_W = 60;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned STAT_W = 16;

    localparam logic [CMD_W-1:0] CMD_READ    = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_INVAL   = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_CLEAR   = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_L2DREQ  = CMD_W'(4);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CMD_W-1:0]    r_command, w_command_nxt;
    logic [ADDR_W-1:0]   r_address, w_address_nxt;
    logic                r_write_d, w_write_d_nxt;
    logic                r_write_i, w_write_i_nxt;
    logic                r_tgt_d, w_tgt_d_nxt;
    logic                r_tgt_i, w_tgt_i_nxt;
    logic                r_ack_d, w_ack_d_nxt;
    logic                r_ack_i, w_ack_i_nxt;
    logic                r_print, w_print_nxt;
    logic [CNT_W-1:0]    r_disp_cnt, w_disp_cnt_nxt;
    logic [STAT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic                w_ready;
    logic                w_all_acked;
    logic                w_all_idle;

`ifdef TRACE_DISPATCH_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMR_W-1:0]    r_timer, w_timer_nxt;
    logic [STAT_W-1:0]   r_to_cnt, w_to_cnt_nxt;
`else
    logic                w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    // Records are only taken while idle and neither cache reports busy.
    assign w_ready = (r_state == S_IDLE) & ~bus.processing_d & ~bus.processing_i;

    // Acks include a processing flag seen this cycle; retire needs all targets quiet.
    assign w_all_acked = (~r_tgt_d | r_ack_d | bus.processing_d) &
                         (~r_tgt_i | r_ack_i | bus.processing_i);
    assign w_all_idle  = (~r_tgt_d | ~bus.processing_d) &
                         (~r_tgt_i | ~bus.processing_i);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state, decode and datapath next values.
    always_comb begin
        w_state_nxt    = r_state;
        w_command_nxt  = r_command;
        w_address_nxt  = r_address;
        w_write_d_nxt  = r_write_d;
        w_write_i_nxt  = r_write_i;
        w_tgt_d_nxt    = r_tgt_d;
        w_tgt_i_nxt    = r_tgt_i;
        w_ack_d_nxt    = r_ack_d;
        w_ack_i_nxt    = r_ack_i;
        w_print_nxt    = 1'b0;
        w_disp_cnt_nxt = r_disp_cnt;
        w_err_cnt_nxt  = r_err_cnt;
`ifdef TRACE_DISPATCH_TIMEOUT_EN
        w_timer_nxt    = r_timer;
        w_to_cnt_nxt   = r_to_cnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.trace_valid && w_ready) begin
                    w_address_nxt = bus.trace_addr;
                    w_ack_d_nxt   = 1'b0;
                    w_ack_i_nxt   = 1'b0;
                    w_tgt_d_nxt   = 1'b0;
                    w_tgt_i_nxt   = 1'b0;
`ifdef TRACE_DISPATCH_TIMEOUT_EN
                    w_timer_nxt   = '0;
`endif
                    case (bus.trace_op)
                        4'd0: begin w_command_nxt = CMD_READ;   w_tgt_d_nxt = 1'b1; end
                        4'd1: begin w_command_nxt = CMD_WRITE;  w_tgt_d_nxt = 1'b1; end
                        4'd2: begin w_command_nxt = CMD_READ;   w_tgt_i_nxt = 1'b1; end
                        4'd3: begin w_command_nxt = CMD_INVAL;  w_tgt_d_nxt = 1'b1; end
                        4'd4: begin w_command_nxt = CMD_L2DREQ; w_tgt_d_nxt = 1'b1; end
                        4'd8: begin
                            w_command_nxt = CMD_CLEAR;
                            w_tgt_d_nxt   = 1'b1;
                            w_tgt_i_nxt   = 1'b1;
                        end
                        4'd9: begin
                            w_print_nxt    = 1'b1;
                            w_disp_cnt_nxt = r_disp_cnt + CNT_W'(1);
                        end
                        default: begin
                            if (r_err_cnt != {STAT_W{1'b1}})
                                w_err_cnt_nxt = r_err_cnt + STAT_W'(1);
                        end
                    endcase
                    w_write_d_nxt = w_tgt_d_nxt;
                    w_write_i_nxt = w_tgt_i_nxt;
                    if (w_tgt_d_nxt || w_tgt_i_nxt)
                        w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_tgt_d && bus.processing_d) begin
                    w_ack_d_nxt   = 1'b1;
                    w_write_d_nxt = 1'b0;
                end
                if (r_tgt_i && bus.processing_i) begin
                    w_ack_i_nxt   = 1'b1;
                    w_write_i_nxt = 1'b0;
                end
`ifdef TRACE_DISPATCH_TIMEOUT_EN
                w_timer_nxt = r_timer + TMR_W'(1);
`endif
                if (w_all_acked) begin
                    w_state_nxt = S_WAIT_DONE;
                end
`ifdef TRACE_DISPATCH_TIMEOUT_EN
                else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_write_d_nxt = 1'b0;
                    w_write_i_nxt = 1'b0;
                    if (r_to_cnt != {STAT_W{1'b1}})
                        w_to_cnt_nxt = r_to_cnt + STAT_W'(1);
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (w_all_idle) begin
                    w_disp_cnt_nxt = r_disp_cnt + CNT_W'(1);
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_command  <= '0;
            r_address  <= '0;
            r_write_d  <= 1'b0;
            r_write_i  <= 1'b0;
            r_tgt_d    <= 1'b0;
            r_tgt_i    <= 1'b0;
            r_ack_d    <= 1'b0;
            r_ack_i    <= 1'b0;
            r_print    <= 1'b0;
            r_disp_cnt <= '0;
            r_err_cnt  <= '0;
`ifdef TRACE_DISPATCH_TIMEOUT_EN
            r_timer    <= '0;
            r_to_cnt   <= '0;
`endif
        end else begin
            r_command  <= w_command_nxt;
            r_address  <= w_address_nxt;
            r_write_d  <= w_write_d_nxt;
            r_write_i  <= w_write_i_nxt;
            r_tgt_d    <= w_tgt_d_nxt;
            r_tgt_i    <= w_tgt_i_nxt;
            r_ack_d    <= w_ack_d_nxt;
            r_ack_i    <= w_ack_i_nxt;
            r_print    <= w_print_nxt;
            r_disp_cnt <= w_disp_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
`ifdef TRACE_DISPATCH_TIMEOUT_EN
            r_timer    <= w_timer_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
`endif
        end
    end

    assign bus.trace_ready   = w_ready;
    assign bus.command       = r_command;
    assign bus.address       = r_address;
    assign bus.write_d       = r_write_d;
    assign bus.write_i       = r_write_i;
    assign print_pulse       = r_print;
    assign busy              = (r_state != S_IDLE);
    assign dispatched_count  = r_disp_cnt;
    assign error_count       = r_err_cnt;
`ifdef TRACE_DISPATCH_TIMEOUT_EN
    assign timeout_count     = r_to_cnt;
`endif

endmodule

// File: tb/tb_trace_dispatcher.sv
// Directed bench for trace_dispatcher: single-cache command, broadcast with
// staggered acks, print/illegal opcodes, back-pressure, mid-command reset and
// (with TRACE_DISPATCH_TIMEOUT_EN) the ISSUE timeout.
module tb_trace_dispatcher;
    logic        clk;
    logic        rst;
    logic        print_pulse;
    logic        busy;
    logic [31:0] dispatched_count;
    logic [15:0] error_count;
`ifdef TRACE_DISPATCH_TIMEOUT_EN
    logic [15:0] timeout_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    trace_dispatcher_if bus();

    trace_dispatcher #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .print_pulse      (print_pulse),
        .busy             (busy),
        .dispatched_count (dispatched_count),
`ifdef TRACE_DISPATCH_TIMEOUT_EN
        .timeout_count    (timeout_count),
`endif
        .error_count      (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.trace_valid  = 1'b0;
        bus.trace_op     = 4'd0;
        bus.trace_addr   = 60'd0;
        bus.processing_d = 1'b0;
        bus.processing_i = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_write_d", 64'(bus.write_d), 64'd0);
        chk("rst_write_i", 64'(bus.write_i), 64'd0);
        chk("rst_command", 64'(bus.command), 64'd0);
        chk("rst_address", 64'(bus.address), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_print",   64'(print_pulse), 64'd0);
        chk("rst_disp",    64'(dispatched_count), 64'd0);
        chk("rst_err",     64'(error_count), 64'd0);
        chk("rst_ready",   64'(bus.trace_ready), 64'd1);
`ifdef TRACE_DISPATCH_TIMEOUT_EN
        chk("rst_timeout", 64'(timeout_count), 64'd0);
`endif
        rst = 1'b1;
        step();

        // Opcode 0: D READ, processing_d raised one cycle after write_d, held 3 cycles
        bus.trace_valid = 1'b1;
        bus.trace_op    = 4'd0;
        bus.trace_addr  = 60'h3865837;
        chk("t1_ready_pre", 64'(bus.trace_ready), 64'd1);
        step();
        bus.trace_valid = 1'b0;
        chk("t1_write_d_c1", 64'(bus.write_d), 64'd1);
        chk("t1_write_i",    64'(bus.write_i), 64'd0);
        chk("t1_command",    64'(bus.command), 64'd0);
        chk("t1_address",    64'(bus.address), 64'h3865837);
        chk("t1_busy",       64'(busy), 64'd1);
        chk("t1_ready_busy", 64'(bus.trace_ready), 64'd0);
        step();
        chk("t1_write_d_c2", 64'(bus.write_d), 64'd1);
        bus.processing_d = 1'b1;
        step();
        chk("t1_write_d_off", 64'(bus.write_d), 64'd0);
        step();
        chk("t1_ready_wait", 64'(bus.trace_ready), 64'd0);
        step();
        bus.processing_d = 1'b0;
        chk("t1_busy_wait", 64'(busy), 64'd1);
        chk("t1_ready_wait2", 64'(bus.trace_ready), 64'd0);
        step();
        chk("t1_busy_done", 64'(busy), 64'd0);
        chk("t1_disp",      64'(dispatched_count), 64'd1);
        chk("t1_ready_post", 64'(bus.trace_ready), 64'd1);
        chk("t1_write_i_end", 64'(bus.write_i), 64'd0);

        // Opcode 8: broadcast CLEAR, D acks at cycle 1, I acks at cycle 4
        bus.trace_valid = 1'b1;
        bus.trace_op    = 4'd8;
        bus.trace_addr  = 60'hABC;
        step();
        bus.trace_valid = 1'b0;
        chk("t2_write_d", 64'(bus.write_d), 64'd1);
        chk("t2_write_i", 64'(bus.write_i), 64'd1);
        chk("t2_command", 64'(bus.command), 64'd3);
        bus.processing_d = 1'b1;
        step();
        chk("t2_write_d_off", 64'(bus.write_d), 64'd0);
        chk("t2_write_i_c2",  64'(bus.write_i), 64'd1);
        step();
        step();
        chk("t2_write_i_c4", 64'(bus.write_i), 64'd1);
        chk("t2_busy_issue", 64'(busy), 64'd1);
        bus.processing_i = 1'b1;
        step();
        chk("t2_write_i_off", 64'(bus.write_i), 64'd0);
        chk("t2_no_retire",   64'(dispatched_count), 64'd1);
        bus.processing_d = 1'b0;
        bus.processing_i = 1'b0;
        step();
        chk("t2_busy_done", 64'(busy), 64'd0);
        chk("t2_disp",      64'(dispatched_count), 64'd2);
        step();
        chk("t2_disp_once", 64'(dispatched_count), 64'd2);

        // Opcode 5 (illegal) then opcode 9 (print)
        bus.trace_valid = 1'b1;
        bus.trace_op    = 4'd5;
        bus.trace_addr  = 60'h55;
        step();
        chk("t3_err",       64'(error_count), 64'd1);
        chk("t3_busy_ill",  64'(busy), 64'd0);
        chk("t3_print_ill", 64'(print_pulse), 64'd0);
        chk("t3_write_ill", 64'({bus.write_d, bus.write_i}), 64'd0);
        bus.trace_op = 4'd9;
        step();
        bus.trace_valid = 1'b0;
        chk("t3_print",     64'(print_pulse), 64'd1);
        chk("t3_disp",      64'(dispatched_count), 64'd3);
        chk("t3_err_hold",  64'(error_count), 64'd1);
        chk("t3_write_prt", 64'({bus.write_d, bus.write_i}), 64'd0);
        chk("t3_busy_prt",  64'(busy), 64'd0);
        step();
        chk("t3_print_off", 64'(print_pulse), 64'd0);
        chk("t3_disp_hold", 64'(dispatched_count), 64'd3);

        // Back-pressure: processing_i high in IDLE blocks accept
        bus.processing_i = 1'b1;
        bus.trace_valid  = 1'b1;
        bus.trace_op     = 4'd0;
        bus.trace_addr   = 60'h5;
        #1;
        chk("t4_ready_blk", 64'(bus.trace_ready), 64'd0);
        step();
        step();
        chk("t4_busy_blk",  64'(busy), 64'd0);
        chk("t4_write_blk", 64'(bus.write_d), 64'd0);
        bus.processing_i = 1'b0;
        #1;
        chk("t4_ready_rel", 64'(bus.trace_ready), 64'd1);
        step();
        bus.trace_valid = 1'b0;
        chk("t4_accept",  64'(bus.write_d), 64'd1);
        chk("t4_addr",    64'(bus.address), 64'h5);

        // Reset pulse during WAIT_DONE drops the record
        bus.processing_d = 1'b1;
        step();
        chk("t5_write_off", 64'(bus.write_d), 64'd0);
        step();
        chk("t5_busy_wait", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("t5_rst_busy",  64'(busy), 64'd0);
        chk("t5_rst_disp",  64'(dispatched_count), 64'd0);
        chk("t5_rst_err",   64'(error_count), 64'd0);
        chk("t5_rst_cmd",   64'(bus.command), 64'd0);
        chk("t5_rst_addr",  64'(bus.address), 64'd0);
        chk("t5_rst_write", 64'({bus.write_d, bus.write_i}), 64'd0);
        bus.processing_d = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t5_disp_after", 64'(dispatched_count), 64'd0);

        // Clean accept after reset: opcode 1 with all-ones address, minimum occupancy
        bus.trace_valid = 1'b1;
        bus.trace_op    = 4'd1;
        bus.trace_addr  = {60{1'b1}};
        step();
        bus.trace_valid = 1'b0;
        chk("t6_write_d", 64'(bus.write_d), 64'd1);
        chk("t6_command", 64'(bus.command), 64'd1);
        chk("t6_address", 64'(bus.address), 64'h0FFF_FFFF_FFFF_FFFF);
        bus.processing_d = 1'b1;
        step();
        bus.processing_d = 1'b0;
        chk("t6_wait_busy", 64'(busy), 64'd1);
        step();
        chk("t6_busy_done", 64'(busy), 64'd0);
        chk("t6_disp",      64'(dispatched_count), 64'd1);
        chk("t6_addr_hold", 64'(bus.address), 64'h0FFF_FFFF_FFFF_FFFF);

        // Opcode 2: I READ
        bus.trace_valid = 1'b1;
        bus.trace_op    = 4'd2;
        bus.trace_addr  = 60'h123;
        step();
        bus.trace_valid = 1'b0;
        chk("t7_write_i", 64'(bus.write_i), 64'd1);
        chk("t7_write_d", 64'(bus.write_d), 64'd0);
        chk("t7_command", 64'(bus.command), 64'd0);
        bus.processing_i = 1'b1;
        step();
        bus.processing_i = 1'b0;
        step();
        chk("t7_disp", 64'(dispatched_count), 64'd2);

`ifdef TRACE_DISPATCH_TIMEOUT_EN
        // Opcode 2 with processing_i never rising: timeout after 16 cycles
        bus.trace_valid = 1'b1;
        bus.trace_op    = 4'd2;
        bus.trace_addr  = 60'h777;
        step();
        bus.trace_valid = 1'b0;
        chk("t8_write_i_on", 64'(bus.write_i), 64'd1);
        for (int i = 0; i < 15; i++) step();
        chk("t8_write_i_c16", 64'(bus.write_i), 64'd1);
        step();
        chk("t8_write_i_off", 64'(bus.write_i), 64'd0);
        chk("t8_timeout",     64'(timeout_count), 64'd1);
        chk("t8_busy",        64'(busy), 64'd0);
        chk("t8_disp",        64'(dispatched_count), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/trace_dispatcher.md
# trace_dispatcher

Upstream feeder for the L1 data and instruction caches. Accepts one trace record at a time (opcode plus 60-bit address) over a valid/ready handshake and routes it to the correct cache or caches as a cache command. It drives each cache's `write` strobe and tracks that cache's `processing` flag until the command retires. It replaces the hand-driven write/processing sequencing in the simulation top and keeps per-record statistics.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: cycles allowed for a cache to raise `processing` after `write` asserts. Used only with the timeout feature.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `trace_valid` in 1: trace record present.
- `trace_op` in 4: trace opcode.
- `trace_addr` in 60: trace address.
- `trace_ready` out 1: record accepted when `trace_valid & trace_ready`.
- `command` out 3: cache command, shared by both caches (READ=0, WRITE=1, INVALIDATE=2, CLEAR=3, L2DATAREQUEST=4).
- `address` out 60: cache address, shared by both caches.
- `write_d` out 1: command strobe to the data cache.
- `write_i` out 1: command strobe to the instruction cache.
- `processing_d` in 1: data cache busy.
- `processing_i` in 1: instruction cache busy.
- `print_pulse` out 1: one-cycle pulse for opcode 9.
- `busy` out 1: high whenever the FSM is not IDLE.
- `dispatched_count` out 32: records retired; wraps.
- `error_count` out 16: illegal opcodes; saturates at 16'hFFFF.
- `timeout_count` out 16: timed-out commands; saturates. Present only with the timeout feature.

## Operation
- Opcode map:
  - 0: D READ.
  - 1: D WRITE.
  - 2: I READ.
  - 3: D INVALIDATE.
  - 4: D L2DATAREQUEST.
  - 8: CLEAR to both caches (broadcast).
  - 9: print. No cache access; asserts `print_pulse`, increments `dispatched_count`.
  - Any other opcode: `error_count`++, no cache access, record consumed.
- States:
  - IDLE: `trace_ready = ~processing_d & ~processing_i`. On accept, latch `command`/`address`.
    - Cache opcode: set the target `write_*` bit(s), go to ISSUE.
    - Opcodes 9 or illegal: handled in the accept cycle, stay in IDLE.
  - ISSUE: each asserted `write_x` clears on the first cycle its `processing_x` is sampled high; that cache is then acked. When every target is acked, go to WAIT_DONE.
  - WAIT_DONE: when every target's `processing` is sampled low, `dispatched_count`++ and go to IDLE.
- A broadcast retires only after both caches ack and both drop `processing`.
- `command`/`address` hold their values from accept until the next accept.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. `trace_ready` follows its IDLE equation.
- Reset asserted mid-command: outputs clear immediately and the in-flight record is dropped, not counted.
- Accept at edge T: `write_x` is high from T+1.
- If `processing_x` is first sampled high at edge T+k, `write_x` is low from T+k+1.
- Retire at edge R, where `processing` is sampled low in WAIT_DONE: `busy` low and the counter updated from R+1. Next accept is possible at R+1.
- Minimum cache command occupancy: 3 cycles (accept, ISSUE, WAIT_DONE).
- `print_pulse` is high for exactly the cycle after accept.
- Simultaneous acks in a broadcast go directly to WAIT_DONE.

## Configuration
- `TRACE_DISPATCH_TIMEOUT_EN` defined:
  - In ISSUE, a per-command counter starts at 0 on entry.
  - If any target is still un-acked after `TIMEOUT_CYCLES` cycles: clear all `write_*`, `timeout_count`++, go to IDLE without incrementing `dispatched_count`.
  - The `timeout_count` port exists.
- Undefined: ISSUE waits indefinitely; no counter logic and no `timeout_count` port.

## Test plan
- Opcode 0, addr 60'h3865837; cache raises `processing_d` 1 cycle after `write_d`, holds it 3 cycles. Required: `write_d` high for 2 cycles, `command`=0, `write_i` stays 0, `dispatched_count`=1, `trace_ready` low until retire+1.
- Opcode 8: `processing_d` acks at cycle 1, `processing_i` at cycle 4. Required: `write_d` clears first, `write_i` stays high through cycle 4, single retire, count +1.
- Opcodes 5 then 9. Required: `error_count`=1, one `print_pulse`, `dispatched_count`=1, no `write_*` activity.
- `trace_valid` held with `processing_i` externally high in IDLE. Required: no accept until `processing_i` falls.
- Reset pulse during WAIT_DONE. Required: all outputs 0 immediately, record not counted, clean accept after release.
- With `TRACE_DISPATCH_TIMEOUT_EN`, opcode 2 and `processing_i` never rising. Required: `write_i` drops after 16 cycles, `timeout_count`=1, `dispatched_count` unchanged.
